// File: rtl/alu_pkg.sv
// Shared constants for the Alu controller: opCodes, FSM encoding, instruction fields.
// Also holds small decode helpers used by the controller.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 6;

    localparam logic [5:0] OP_ADD = 6'd0;
    localparam logic [5:0] OP_SUB = 6'd1;
    localparam logic [5:0] OP_AND = 6'd2;
    localparam logic [5:0] OP_OR  = 6'd3;
    localparam logic [5:0] OP_XOR = 6'd4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;

    localparam int OPC_MSB    = 31;
    localparam int OPC_LSB    = 26;
    localparam int RD_MSB     = 25;
    localparam int RD_LSB     = 23;
    localparam int RS1_MSB    = 22;
    localparam int RS1_LSB    = 20;
    localparam int RS2_MSB    = 19;
    localparam int RS2_LSB    = 17;
    localparam int IMMSEL_BIT = 16;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    function automatic logic is_legal_op(input logic [5:0] op);
        return op <= OP_XOR;
    endfunction

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8x32 register file: two combinational read ports, a debug read port and one write port.
// Register 0 is held at zero by never writing it.
module alu_regfile
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              resetN,
    input  logic              we,
    input  logic [2:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [2:0]        raddr1,
    input  logic [2:0]        raddr2,
    input  logic [2:0]        dbg_addr,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] dbg_data
);

    logic [DATA_W-1:0] regs [8];

    // NOTE: the array is small and must read as zero straight out of reset, so every
    // entry sits on the async clear rather than relying on an unreset RAM.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != 3'd0)) begin
            // NOTE: non-blocking so a same-edge read elsewhere still sees the old value.
            regs[waddr] <= wdata;
        end
    end

    assign rdata1   = regs[raddr1];
    assign rdata2   = regs[raddr2];
    assign dbg_data = regs[dbg_addr];

endmodule

// File: rtl/alu_controller.sv
// Four-state issue controller for the Alu: IDLE -> READ -> EXEC -> WRITE.
// Accepts one instruction per handshake, reads operands, captures the result, writes it back.
module alu_controller
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        resetN,
    input  logic [31:0] instr,
    input  logic        instrValid,
    output logic        instrReady,
    output logic [31:0] aluOperand1,
    output logic [31:0] aluOperand2,
    output logic [5:0]  aluOpCode,
    input  logic [31:0] aluResult,
    output logic        done,
    output logic        error,
    input  logic [2:0]  dbgAddr,
    output logic [31:0] dbgData
);

    logic [1:0]  state;
    logic [31:0] instr_q;
    logic [31:0] result_q;
    logic        illegal_q;

    logic [5:0]  opcode;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic        imm_sel;
    logic [15:0] imm;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] operand2;
    logic        wb_en;

    assign opcode   = instr_q[OPC_MSB:OPC_LSB];
    assign rd       = instr_q[RD_MSB:RD_LSB];
    assign rs1      = instr_q[RS1_MSB:RS1_LSB];
    assign rs2      = instr_q[RS2_MSB:RS2_LSB];
    assign imm_sel  = instr_q[IMMSEL_BIT];
    assign imm      = instr_q[IMM_MSB:IMM_LSB];
    assign operand2 = imm_sel ? sign_ext16(imm) : rdata2;
    assign wb_en    = (state == ST_WRITE) && !illegal_q;

    alu_regfile u_regfile (
        .clk      (clk),
        .resetN   (resetN),
        .we       (wb_en),
        .waddr    (rd),
        .wdata    (result_q),
        .raddr1   (rs1),
        .raddr2   (rs2),
        .dbg_addr (dbgAddr),
        .rdata1   (rdata1),
        .rdata2   (rdata2),
        .dbg_data (dbgData)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= ST_IDLE;
            instrReady  <= 1'b1;
            instr_q     <= '0;
            result_q    <= '0;
            illegal_q   <= 1'b0;
            aluOperand1 <= '0;
            aluOperand2 <= '0;
            aluOpCode   <= '0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (instrValid && instrReady) begin
                        instr_q    <= instr;
                        instrReady <= 1'b0;
                        state      <= ST_READ;
                    end
                end
                // Operands are latched straight into the Alu-facing registers so they
                // are stable for all of EXEC and hold afterwards.
                ST_READ: begin
                    aluOperand1 <= rdata1;
                    aluOperand2 <= operand2;
                    aluOpCode   <= is_legal_op(opcode) ? opcode : OP_ADD;
                    illegal_q   <= !is_legal_op(opcode);
                    state       <= ST_EXEC;
                end
                ST_EXEC: begin
                    result_q <= aluResult;
                    done     <= 1'b1;
                    error    <= illegal_q;
                    state    <= ST_WRITE;
                end
                ST_WRITE: begin
                    instrReady <= 1'b1;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_controller.sv
// Self-checking bench for alu_controller: behavioural Alu plus a register-array reference model.
// Directed test-plan steps followed by randomized instructions.
module tb_alu_controller;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        resetN;
    logic [31:0] instr;
    logic        instrValid;
    logic        instrReady;
    logic [31:0] aluOperand1;
    logic [31:0] aluOperand2;
    logic [5:0]  aluOpCode;
    logic [31:0] aluResult;
    logic        done;
    logic        error;
    logic [2:0]  dbgAddr;
    logic [31:0] dbgData;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [8];

    always #5 clk = ~clk;

    alu_controller dut (
        .clk         (clk),
        .resetN      (resetN),
        .instr       (instr),
        .instrValid  (instrValid),
        .instrReady  (instrReady),
        .aluOperand1 (aluOperand1),
        .aluOperand2 (aluOperand2),
        .aluOpCode   (aluOpCode),
        .aluResult   (aluResult),
        .done        (done),
        .error       (error),
        .dbgAddr     (dbgAddr),
        .dbgData     (dbgData)
    );

    function automatic logic [31:0] ref_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            6'd0:    return a + b;
            6'd1:    return a - b;
            6'd2:    return a & b;
            6'd3:    return a | b;
            6'd4:    return a ^ b;
            default: return 32'd0;
        endcase
    endfunction

    // Stand-in for the combinational Alu block.
    assign aluResult = ref_op(aluOpCode, aluOperand1, aluOperand2);

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                                        input logic [2:0] rs2, input logic isel, input logic [15:0] imm);
        return {op, rd, rs1, rs2, isel, imm};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (instrReady !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "/ready_wait"}, {31'd0, instrReady}, 32'd1);
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbgAddr = 3'(i);
            @(negedge clk);
            check($sformatf("%s/r%0d", tag, i), dbgData, model[i]);
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                             input logic [2:0] rs2, input logic isel, input logic [15:0] imm, input string tag);
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        legal;
        a     = model[rs1];
        b     = isel ? {{16{imm[15]}}, imm} : model[rs2];
        legal = (op < 6'd5);
        res   = ref_op(op, a, b);
        wait_ready(tag);
        instr      = enc(op, rd, rs1, rs2, isel, imm);
        instrValid = 1'b1;
        @(posedge clk); #1;
        instrValid = 1'b0;
        check({tag, "/read_ready"}, {31'd0, instrReady}, 32'd0);
        check({tag, "/read_done"},  {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        check({tag, "/exec_op1"}, aluOperand1, a);
        check({tag, "/exec_op2"}, aluOperand2, b);
        check({tag, "/exec_opc"}, {26'd0, aluOpCode}, legal ? {26'd0, op} : 32'd0);
        @(posedge clk); #1;
        check({tag, "/write_done"},  {31'd0, done}, 32'd1);
        check({tag, "/write_error"}, {31'd0, error}, {31'd0, !legal});
        @(posedge clk); #1;
        check({tag, "/idle_done"},  {31'd0, done}, 32'd0);
        check({tag, "/idle_ready"}, {31'd0, instrReady}, 32'd1);
        if (legal && rd != 3'd0) model[rd] = res;
        dbgAddr = rd;
        #1;
        check({tag, "/dbg_rd"}, dbgData, model[rd]);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ready_cnt;
        int done_cnt;
        for (int i = 0; i < 8; i++) model[i] = 32'd0;
        resetN     = 1'b0;
        instr      = 32'd0;
        instrValid = 1'b0;
        dbgAddr    = 3'd0;
        #12;
        check("rst/ready", {31'd0, instrReady}, 32'd1);
        check("rst/op1",   aluOperand1, 32'd0);
        check("rst/op2",   aluOperand2, 32'd0);
        check("rst/opc",   {26'd0, aluOpCode}, 32'd0);
        check("rst/done",  {31'd0, done}, 32'd0);
        check("rst/error", {31'd0, error}, 32'd0);
        check_all_regs("rst");
        @(negedge clk);
        resetN = 1'b1;
        @(posedge clk); #1;

        run_instr(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'd2, "r1_imm2");
        run_instr(OP_ADD, 3'd2, 3'd0, 3'd0, 1'b1, 16'd3, "r2_imm3");
        run_instr(OP_ADD, 3'd3, 3'd1, 3'd2, 1'b0, 16'd0, "add_r3");
        check("add_r3_is_5", model[3], 32'd5);
        run_instr(OP_SUB, 3'd4, 3'd1, 3'd2, 1'b0, 16'd0, "sub_r4");
        run_instr(OP_AND, 3'd5, 3'd1, 3'd2, 1'b0, 16'd0, "and_r5");
        run_instr(OP_OR,  3'd6, 3'd1, 3'd2, 1'b0, 16'd0, "or_r6");
        run_instr(OP_XOR, 3'd7, 3'd1, 3'd2, 1'b0, 16'd0, "xor_r7");
        check_all_regs("logic");

        run_instr(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h8000, "sext_r1");
        run_instr(OP_ADD, 3'd0, 3'd2, 3'd0, 1'b1, 16'd5, "rd0");
        run_instr(6'd5,   3'd4, 3'd1, 3'd2, 1'b0, 16'd0, "illegal5");
        check_all_regs("post_illegal");

        // Dependent chain with instrValid held high the whole time.
        run_instr(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'd2, "chain_seed");
        instr      = enc(OP_ADD, 3'd1, 3'd1, 3'd1, 1'b0, 16'd0);
        instrValid = 1'b1;
        ready_cnt  = 0;
        done_cnt   = 0;
        for (int c = 0; c < 16; c++) begin
            ready_cnt += int'(instrReady);
            done_cnt  += int'(done);
            @(posedge clk); #1;
        end
        instrValid = 1'b0;
        check("hold/ready_cycles", ready_cnt, 32'd4);
        check("hold/done_pulses",  done_cnt,  32'd4);
        model[1] = 32'd32;
        dbgAddr = 3'd1;
        #1;
        check("hold/r1_is_32", dbgData, model[1]);
        @(posedge clk); #1;
        check("hold/no_extra_accept", {31'd0, instrReady}, 32'd1);

        for (int k = 0; k < 24; k++) begin
            run_instr(6'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                      3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 16'($urandom),
                      $sformatf("rand%0d", k));
        end
        check_all_regs("rand");

        // Reset asserted during EXEC.
        run_instr(OP_ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h1234, "pre_rst");
        wait_ready("midrst");
        instr      = enc(OP_ADD, 3'd3, 3'd1, 3'd0, 1'b1, 16'd7);
        instrValid = 1'b1;
        @(posedge clk); #1;
        instrValid = 1'b0;
        @(posedge clk); #1;
        check("midrst/exec_op1", aluOperand1, 32'h1234);
        resetN = 1'b0;
        #1;
        check("midrst/ready", {31'd0, instrReady}, 32'd1);
        check("midrst/op1",   aluOperand1, 32'd0);
        check("midrst/op2",   aluOperand2, 32'd0);
        check("midrst/opc",   {26'd0, aluOpCode}, 32'd0);
        check("midrst/done",  {31'd0, done}, 32'd0);
        check("midrst/error", {31'd0, error}, 32'd0);
        for (int i = 0; i < 8; i++) model[i] = 32'd0;
        done_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            done_cnt += int'(done);
        end
        check("midrst/no_done", done_cnt, 32'd0);
        check_all_regs("midrst");
        resetN = 1'b1;
        @(posedge clk); #1;
        run_instr(OP_SUB, 3'd2, 3'd0, 3'd0, 1'b1, 16'd1, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
